// File: rtl/mul_pipe.sv
// mul_pipe: pipelined radix-4 Booth / Wallace-tree multiplier with elastic valid/ready
// handshakes, a global stall and a flush that kills all in-flight operations.
module mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic               mul_clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         mul_op,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int P = 2 * WIDTH;
  localparam int NPP = WIDTH / 2 + 1;
  function automatic int rows(input int lvl);
    int n = NPP;
    for (int l = 0; l < lvl; l++) n = n - n / 3;
    return n;
  endfunction
  function automatic int levels();
    int n = NPP;
    int l = 0;
    while (n > 3) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction
  localparam int LV = levels();
  logic adv, acc, sgn, lo_s, lo_c, v_s, v_c;
  logic [P-1:0] xe, s_n, c_n, s_q, c_q, prod_n;
  logic [WIDTH+2:0] ye;
  logic [P-1:0] pp [NPP];
  logic [P-1:0] pp_s [NPP];
  logic [P-1:0] t [LV+1][NPP];
  logic [TAG_W-1:0] tag_s, tag_c;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv & ~flush;
  assign acc = in_valid & in_ready;
  assign sgn = mul_op[0] | mul_op[1];
  assign xe = {{WIDTH{x[WIDTH-1] & sgn}}, x};
  assign ye = {{2{y[WIDTH-1] & sgn}}, y, 1'b0};
  for (genvar i = 0; i < NPP; i++) begin : g_booth
    logic [2:0] d;
    logic [P-1:0] m;
    assign d = ye[2*i+2:2*i];
    assign m = (d == 3'b001 || d == 3'b010) ? xe
             : (d == 3'b101 || d == 3'b110) ? -xe
             : (d == 3'b011) ? xe << 1
             : (d == 3'b100) ? -(xe << 1) : '0;
    assign pp[i] = m << (2 * i);
  end
  if (STAGES == 3) begin : g_s3
    always_ff @(posedge mul_clk) begin
      if (reset || flush) v_s <= 1'b0;
      else if (adv) v_s <= acc;
      if (adv) begin
        pp_s <= pp;
        lo_s <= mul_op[0];
        tag_s <= in_tag;
      end
    end
  end else begin : g_s2
    assign v_s = acc;
    assign pp_s = pp;
    assign lo_s = mul_op[0];
    assign tag_s = in_tag;
  end
  // each level compresses groups of three rows into sum + shifted carry; leftovers pass down
  assign t[0] = pp_s;
  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int N = rows(l);
    localparam int G = N / 3;
    for (genvar k = 0; k < G; k++) begin : g_csa
      assign t[l+1][2*k] = t[l][3*k] ^ t[l][3*k+1] ^ t[l][3*k+2];
      assign t[l+1][2*k+1] = ((t[l][3*k] & t[l][3*k+1]) | (t[l][3*k+2] & (t[l][3*k] | t[l][3*k+1]))) << 1;
    end
    for (genvar k = 3 * G; k < N; k++) begin : g_pass
      assign t[l+1][k-G] = t[l][k];
    end
    for (genvar k = N - G; k < NPP; k++) begin : g_zero
      assign t[l+1][k] = '0;
    end
  end
  assign s_n = t[LV][0] ^ t[LV][1] ^ t[LV][2];
  assign c_n = (t[LV][0] & t[LV][1]) | (t[LV][2] & (t[LV][0] | t[LV][1]));
  assign prod_n = s_q + (c_q << 1);
  always_ff @(posedge mul_clk) begin
    if (reset || flush) begin
      v_c <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v_c <= v_s;
      out_valid <= v_c;
    end
    if (adv) begin
      s_q <= s_n;
      c_q <= c_n;
      lo_c <= lo_s;
      tag_c <= tag_s;
    end
    if (reset) begin
      product <= '0;
      result <= '0;
      out_tag <= '0;
    end else if (adv) begin
      product <= prod_n;
      result <= lo_c ? prod_n[WIDTH-1:0] : prod_n[P-1:WIDTH];
      out_tag <= tag_c;
    end
  end
endmodule
